// File: rtl/surf4_hk_sequencer.sv
// rtl/surf4_hk_sequencer.sv - PPS-triggered XADC-to-housekeeping-buffer WISHBONE copy sequencer
module surf4_hk_sequencer #(
    parameter int unsigned NUM_CH   = 8,
    parameter logic [15:0] SRC_BASE = 16'h0200,
    parameter logic [15:0] DST_BASE = 16'h0400,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pps_i,
    output logic        wbmc_cyc_o,
    output logic        wbmc_stb_o,
    output logic        wbmc_we_o,
    output logic [15:0] wbmc_adr_o,
    output logic [31:0] wbmc_dat_o,
    output logic [3:0]  wbmc_sel_o,
    input  logic [31:0] wbmc_dat_i,
    input  logic        wbmc_ack_i,
    input  logic        wbmc_err_i,
    input  logic        wbmc_rty_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  err_cnt_o,
    output logic [31:0] scan_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_GAP,
        S_WR,
        S_WR_GAP,
        S_HDR,
        S_DONE
    } state_t;

    // Header word sits immediately after the last channel word.
    localparam logic [15:0] HDR_ADR = 16'(DST_BASE + 4 * NUM_CH);

    state_t      state;
    state_t      state_nx;
    logic        pps_q;
    logic        pps_edge;
    logic        pending;
    logic [6:0]  ch;
    logic        last_ch;
    logic [7:0]  tmo_cnt;
    logic        tmo_hit;
    logic [31:0] cap;
    logic [7:0]  err_cnt;
    logic [31:0] scan_cnt;
    logic        xfer;
    logic        xfer_end;
    logic        xfer_err;

    assign pps_edge = pps_i & ~pps_q;
    assign last_ch  = (ch == 7'(NUM_CH - 1));
    assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT));
    assign xfer     = (state == S_RD) || (state == S_WR) || (state == S_HDR);
    // A transfer ends on any termination or timeout; ack wins over err/rty.
    assign xfer_end = xfer & (wbmc_ack_i | wbmc_err_i | wbmc_rty_i | tmo_hit);
    assign xfer_err = xfer & ~wbmc_ack_i & (wbmc_err_i | wbmc_rty_i | tmo_hit);

    assign wbmc_sel_o = 4'hF;
    assign err_cnt_o  = err_cnt;
    assign scan_cnt_o = scan_cnt;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state and bus outputs, decoded from the current state.
    always_comb begin
        state_nx   = state;
        wbmc_cyc_o = 1'b0;
        wbmc_stb_o = 1'b0;
        wbmc_we_o  = 1'b0;
        wbmc_adr_o = 16'h0000;
        wbmc_dat_o = 32'h0000_0000;
        done_o     = 1'b0;
        busy_o     = 1'b1;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (pps_edge || pending) state_nx = S_RD;
            end
            S_RD: begin
                wbmc_cyc_o = 1'b1;
                wbmc_stb_o = 1'b1;
                wbmc_adr_o = SRC_BASE + {7'd0, ch, 2'b00};
                if (xfer_end) state_nx = S_RD_GAP;
            end
            S_RD_GAP: state_nx = S_WR;
            S_WR: begin
                wbmc_cyc_o = 1'b1;
                wbmc_stb_o = 1'b1;
                wbmc_we_o  = 1'b1;
                wbmc_adr_o = DST_BASE + {7'd0, ch, 2'b00};
                wbmc_dat_o = cap;
                if (xfer_end) state_nx = S_WR_GAP;
            end
            S_WR_GAP: state_nx = last_ch ? S_HDR : S_RD;
            S_HDR: begin
                wbmc_cyc_o = 1'b1;
                wbmc_stb_o = 1'b1;
                wbmc_we_o  = 1'b1;
                wbmc_adr_o = HDR_ADR;
                wbmc_dat_o = scan_cnt + 32'd1;
                if (xfer_end) state_nx = S_DONE;
            end
            S_DONE: begin
                done_o   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // PPS edge history and the single-deep pending request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pps_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            pps_q <= pps_i;
            if (state == S_IDLE) pending <= 1'b0;
            else if (pps_edge)   pending <= 1'b1;
        end
    end

    // Channel index: restarts every scan, advances after each channel's write gap.
    always_ff @(posedge clk_i) begin
        if (rst_i || state == S_IDLE)             ch <= 7'd0;
        else if (state == S_WR_GAP && !last_ch)   ch <= ch + 7'd1;
    end

    // Strobe-age counter; zero whenever no transfer is outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i)                 tmo_cnt <= 8'd0;
        else if (xfer && !xfer_end) tmo_cnt <= tmo_cnt + 8'd1;
        else                       tmo_cnt <= 8'd0;
    end

    // Read capture; failed reads are replaced by an all-ones marker word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap <= 32'h0000_0000;
        end else if (state == S_RD && xfer_end) begin
            cap <= wbmc_ack_i ? wbmc_dat_i : 32'hFFFF_FFFF;
        end
    end

    // Error and scan counters; err_cnt saturates and persists across scans.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt  <= 8'd0;
            scan_cnt <= 32'd0;
        end else begin
            if (xfer_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (state == S_DONE)              scan_cnt <= scan_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_surf4_hk_sequencer.sv
// tb/tb_surf4_hk_sequencer.sv - scoreboard bench for surf4_hk_sequencer
module tb_surf4_hk_sequencer;

    typedef struct packed {
        logic [15:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pps = 1'b0;
    logic        cyc, stb, we;
    logic [15:0] adr;
    logic [31:0] dat_o;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic        ack, err, rty;
    logic        busy, done;
    logic [7:0]  err_cnt;
    logic [31:0] scan_cnt;

    int errors = 0;
    int checks = 0;

    wr_t         exp_q[$];
    logic [31:0] exp_scan = 0;
    int          cyc_no = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          hang_stb = 0;
    int          bus_cnt = 0;

    logic        err_rd_en = 0;
    logic [15:0] err_rd_adr = 16'h0;
    logic        hang_en = 0;
    logic [15:0] hang_adr = 16'h0;
    logic        both_en = 0;

    surf4_hk_sequencer #(
        .NUM_CH  (8),
        .SRC_BASE(16'h0200),
        .DST_BASE(16'h0400),
        .TIMEOUT (10)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .pps_i     (pps),
        .wbmc_cyc_o(cyc),
        .wbmc_stb_o(stb),
        .wbmc_we_o (we),
        .wbmc_adr_o(adr),
        .wbmc_dat_o(dat_o),
        .wbmc_sel_o(sel),
        .wbmc_dat_i(dat_i),
        .wbmc_ack_i(ack),
        .wbmc_err_i(err),
        .wbmc_rty_i(rty),
        .busy_o    (busy),
        .done_o    (done),
        .err_cnt_o (err_cnt),
        .scan_cnt_o(scan_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Zero-wait slave returning the address as read data, with fault knobs.
    always @* begin
        ack   = 1'b0;
        err   = 1'b0;
        rty   = 1'b0;
        dat_i = 32'h0;
        if (cyc && stb) begin
            dat_i = {16'h0, adr};
            if (hang_en && we && adr == hang_adr) begin
                ack = 1'b0;
            end else if (err_rd_en && !we && adr == err_rd_adr) begin
                err = 1'b1;
            end else begin
                ack = 1'b1;
                if (both_en) err = 1'b1;
            end
        end
    end

    // Monitor: compare accepted writes against the scoreboard, track timing.
    always @(negedge clk) begin
        cyc_no = cyc_no + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc_no;
        end
        if (stb && we && adr == hang_adr) hang_stb = hang_stb + 1;
        if (cyc) bus_cnt = bus_cnt + 1;
        if (cyc && stb && we && ack) begin
            if (exp_q.size() == 0) begin
                check("unexp_wr", {16'h0, adr}, 32'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_adr", {16'h0, adr}, {16'h0, e.adr});
                check("wr_dat", dat_o, e.dat);
            end
        end
    end

    task automatic push_scan(input int err_ch, input int skip_ch, input int upto);
        for (int i = 0; i < 8 && i <= upto; i++) begin
            wr_t e;
            e.adr = 16'h0400 + 16'(4 * i);
            e.dat = (i == err_ch) ? 32'hFFFF_FFFF : {16'h0, 16'h0200 + 16'(4 * i)};
            if (i != skip_ch) exp_q.push_back(e);
        end
        if (upto >= 8) begin
            wr_t h;
            exp_scan = exp_scan + 1;
            h.adr = 16'h0420;
            h.dat = exp_scan;
            exp_q.push_back(h);
        end
    endtask

    task automatic pulse_pps();
        @(posedge clk);
        #1 pps = 1'b1;
        cyc_no = 0;
        @(posedge clk);
        #1 pps = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("done_reached", (done_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int dc;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cyc", {31'h0, cyc}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_adr", {16'h0, adr}, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_err", {24'h0, err_cnt}, 32'h0);
        check("rst_scan", scan_cnt, 32'h0);

        // Clean scan with a zero-wait slave.
        push_scan(-1, -1, 8);
        dc = done_cnt;
        pulse_pps();
        wait_done(dc + 1);
        check("done_cycle", done_cyc, 35);
        check("scan1", scan_cnt, 1);
        check("err1", {24'h0, err_cnt}, 0);
        check("sel", {28'h0, sel}, 32'hF);
        check("q_empty1", exp_q.size(), 0);

        // Error on the read of 0x0208.
        err_rd_en = 1'b1;
        err_rd_adr = 16'h0208;
        push_scan(2, -1, 8);
        dc = done_cnt;
        pulse_pps();
        wait_done(dc + 1);
        err_rd_en = 1'b0;
        check("err2", {24'h0, err_cnt}, 1);
        check("scan2", scan_cnt, 2);
        check("q_empty2", exp_q.size(), 0);

        // Write to 0x0404 never terminates; timeout after 11 strobe cycles.
        hang_en = 1'b1;
        hang_adr = 16'h0404;
        push_scan(-1, 1, 8);
        dc = done_cnt;
        hang_stb = 0;
        pulse_pps();
        wait_done(dc + 1);
        hang_en = 1'b0;
        check("hang_stb", hang_stb, 11);
        check("err3", {24'h0, err_cnt}, 2);
        check("scan3", scan_cnt, 3);
        check("q_empty3", exp_q.size(), 0);

        // ack and err together: ack wins, no error counted.
        both_en = 1'b1;
        push_scan(-1, -1, 8);
        dc = done_cnt;
        pulse_pps();
        wait_done(dc + 1);
        both_en = 1'b0;
        check("err4", {24'h0, err_cnt}, 2);
        check("scan4", scan_cnt, 4);
        check("q_empty4", exp_q.size(), 0);

        // Three PPS edges in one scan: one runs, one pends, one is dropped.
        push_scan(-1, -1, 8);
        push_scan(-1, -1, 8);
        dc = done_cnt;
        pulse_pps();
        repeat (4) @(posedge clk);
        pulse_pps();
        repeat (4) @(posedge clk);
        pulse_pps();
        wait_done(dc + 2);
        repeat (100) @(negedge clk);
        check("pps_scans", done_cnt - dc, 2);
        check("scan6", scan_cnt, 6);
        check("q_empty6", exp_q.size(), 0);

        // Reset during the write of channel 3.
        push_scan(-1, -1, 3);
        pulse_pps();
        begin
            int k;
            k = 0;
            while (!(cyc && stb && we && adr == 16'h040C) && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("wr3_seen", {16'h0, adr}, 32'h040C);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_cyc", {31'h0, cyc}, 32'h0);
        check("rst_mid_err", {24'h0, err_cnt}, 32'h0);
        check("rst_mid_scan", scan_cnt, 32'h0);
        bus_cnt = 0;
        repeat (60) @(negedge clk);
        check("no_restart", bus_cnt, 0);
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("q_empty7", exp_q.size(), 0);

        exp_scan = 0;
        exp_q.delete();
        push_scan(-1, -1, 8);
        dc = done_cnt;
        pulse_pps();
        wait_done(dc + 1);
        check("scan_after_rst", scan_cnt, 1);
        check("q_empty8", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
